cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 20 ++
 rtl/sat_counter.sv | 26 ++
 rtl/cache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_t;

  // Word-offset width within a line, e.g. 4 words -> 2 bits.
  function automatic int word_off_w(input int words);
    return $clog2(words);
  endfunction

  localparam int CACHE_LINE_WORDS = 4;
  localparam int CACHE_OFF_W      = word_off_w(CACHE_LINE_WORDS);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous preload, cleared by reset.
// Latency: count updates one clk after inc/load.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Preload wins over increment; increment stops at the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Blocking cache controller: read-miss line refill, write-through no-allocate stores.
// Latency: read hit 0 stall cycles, read miss 1+LINE_WORDS, store 1.
// Backpressure: stall freezes the CPU pipeline; optional counters via CACHE_CTRL_PERF_EN.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  LINE_WORDS = CACHE_LINE_WORDS,
  localparam int OFF_W      = word_off_w(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  hit,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fill_en,
  output logic [OFF_W-1:0]      fill_idx,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  tag_wr
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  // Clears the word offset and byte bits to get the line base address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << (OFF_W + 2)) - 1);
  // Byte lanes are ignored: only whole-word accesses exist.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  cache_state_t          state_q;
  cache_state_t          state_d;
  logic [OFF_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hit_q;
  logic                  rd_miss;
  logic                  wr_req;
  logic                  last_beat;

  assign rd_miss   = (state_q == IDLE) && req_valid && !req_we && !hit;
  assign wr_req    = (state_q == IDLE) && req_valid && req_we;
  assign last_beat = (cnt_q == OFF_W'(LINE_WORDS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a refill always runs to its last word regardless of req_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_miss) begin
          state_d = REFILL;
        end else if (wr_req) begin
          state_d = WRITE;
        end
      end
      REFILL:  if (last_beat) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Refill beat counter, line base and the captured store request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (rd_miss) begin
        base_q <= req_addr & LINE_MASK;
        cnt_q  <= '0;
      end else if (state_q == REFILL) begin
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
      if (wr_req) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        hit_q   <= hit;
      end
    end
  end

  // Output decode; everything is forced quiet while reset is held.
  always_comb begin
    stall     = 1'b0;
    mem_addr  = req_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    fill_en   = 1'b0;
    fill_idx  = '0;
    fill_data = '0;
    tag_wr    = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: stall = rd_miss || wr_req;
        REFILL: begin
          stall     = 1'b1;
          mem_addr  = base_q + ADDR_WIDTH'({cnt_q, 2'b00});
          fill_en   = 1'b1;
          fill_idx  = cnt_q;
          fill_data = mem_rdata;
          tag_wr    = last_beat;
        end
        WRITE: begin
          mem_we    = 1'b1;
          mem_addr  = addr_q & WORD_MASK;
          mem_wdata = wdata_q;
          if (hit_q) begin
            fill_en   = 1'b1;
            fill_idx  = addr_q[OFF_W+1:2];
            fill_data = wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic rd_hit;
  assign rd_hit = (state_q == IDLE) && req_valid && !req_we && hit;

  sat_counter #(.WIDTH(32)) u_hit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val (32'd0),
    .inc      (rd_hit),
    .count    (hit_cnt)
  );

  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val (32'd0),
    .inc      (rd_miss),
    .count    (miss_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl plus a standalone sat_counter.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: the bench follows stall by construction of each transaction.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int LW = 4;
  localparam int OW = CACHE_OFF_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, hit;
  logic [31:0]   req_addr, req_wdata;
  logic          stall, mem_we, fill_en, tag_wr;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [OW-1:0] fill_idx;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif
  logic          sat_load, sat_inc;
  logic [31:0]   sat_val, sat_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // Backing memory: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  cache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .hit       (hit),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fill_en   (fill_en),
    .fill_idx  (fill_idx),
    .fill_data (fill_data),
    .tag_wr    (tag_wr)
`ifdef CACHE_CTRL_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  sat_counter #(.WIDTH(32)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sat_load),
    .load_val (sat_val),
    .inc      (sat_inc),
    .count    (sat_cnt)
  );

  typedef struct {
    logic          stall, mem_we, fill_en, tag_wr;
    logic [31:0]   mem_addr;
    logic [OW-1:0] fill_idx;
    logic [31:0]   fill_data, mem_wdata;
  } out_t;

  typedef struct {
    logic        v, we, h;
    logic [31:0] a, d;
    logic        exp_stall;
    logic [31:0] exp_mem_addr;
  } vec_t;

  // Which line bases the (external) tag array currently holds valid.
  bit line_valid [logic [31:0]];

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic out_t o_idle(input logic [31:0] a, input logic st);
    out_t o;
    o.stall = st; o.mem_we = 1'b0; o.fill_en = 1'b0; o.tag_wr = 1'b0;
    o.mem_addr = a; o.fill_idx = '0; o.fill_data = '0; o.mem_wdata = '0;
    return o;
  endfunction

  function automatic out_t o_refill(input logic [31:0] base, input int i);
    out_t o;
    o.stall = 1'b1; o.mem_we = 1'b0; o.fill_en = 1'b1; o.tag_wr = (i == LW - 1);
    o.mem_addr = base + 32'(4 * i); o.fill_idx = OW'(i);
    o.fill_data = mem_word(base + 32'(4 * i)); o.mem_wdata = '0;
    return o;
  endfunction

  function automatic out_t o_write(input logic [31:0] a, input logic [31:0] d, input logic h);
    out_t o;
    o.stall = 1'b0; o.mem_we = 1'b1; o.fill_en = h; o.tag_wr = 1'b0;
    o.mem_addr = a & ~32'd3; o.mem_wdata = d;
    o.fill_idx = h ? OW'((a >> 2) % LW) : '0;
    o.fill_data = h ? d : '0;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input out_t e);
    chk({nm, ".stall"},     32'(stall),     32'(e.stall));
    chk({nm, ".mem_we"},    32'(mem_we),    32'(e.mem_we));
    chk({nm, ".fill_en"},   32'(fill_en),   32'(e.fill_en));
    chk({nm, ".tag_wr"},    32'(tag_wr),    32'(e.tag_wr));
    chk({nm, ".mem_addr"},  mem_addr,       e.mem_addr);
    chk({nm, ".fill_idx"},  32'(fill_idx),  32'(e.fill_idx));
    chk({nm, ".fill_data"}, fill_data,      e.fill_data);
    chk({nm, ".mem_wdata"}, mem_wdata,      e.mem_wdata);
  endtask

  task automatic drive(input logic v, input logic we, input logic h,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_we = we; hit = h; req_addr = a; req_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read as the CPU sees it; drop releases req_valid mid-refill.
  task automatic t_read(input logic [31:0] a, input bit drop);
    logic        h;
    logic [31:0] base;
    h = line_valid.exists(line_of(a));
    drive(1'b1, 1'b0, h, a, $urandom);
    @(negedge clk);
    if (h) begin
      chk_outs("rd_hit", o_idle(a, 1'b0));
      next_cycle();
      return;
    end
    chk_outs("rd_miss", o_idle(a, 1'b1));
    base = line_of(a);
    for (int i = 0; i < LW; i++) begin
      next_cycle();
      if (drop && i == 1) drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
      @(negedge clk);
      chk_outs($sformatf("refill%0d", i), o_refill(base, i));
    end
    line_valid[base] = 1'b1;
    next_cycle();
    if (!drop) begin
      drive(1'b1, 1'b0, 1'b1, a, $urandom);
      @(negedge clk);
      chk_outs("miss_resolve", o_idle(a, 1'b0));
      next_cycle();
    end
  endtask

  task automatic t_write(input logic [31:0] a, input logic [31:0] d);
    logic h;
    h = line_valid.exists(line_of(a));
    drive(1'b1, 1'b1, h, a, d);
    @(negedge clk);
    chk_outs("st_req", o_idle(a, 1'b1));
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    chk_outs("st_write", o_write(a, d, h));
    next_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    int          sc;
    logic [31:0] a;

    sat_load = 1'b0; sat_inc = 1'b0; sat_val = '0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0001_0004, 32'h0);
    #3;
    // Reset: a read miss on the inputs must not raise stall while reset is held.
    chk_outs("reset_miss", o_idle(32'h0001_0004, 1'b0));
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk_outs("reset_idle", o_idle(32'd0, 1'b0));
    chk("reset_sat", sat_cnt, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single-cycle IDLE vectors: no transition expected.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0001_0004, 32'h0, 1'b0, 32'h0001_0004};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h5, 1'b0, 32'h0000_1234};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hABCD_EF01, 32'h7, 1'b0, 32'hABCD_EF01};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 1'b0, 32'h0000_0003};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 32'h8000_0000};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].h, vecs[i].a, vecs[i].d);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), o_idle(vecs[i].exp_mem_addr, vecs[i].exp_stall));
      next_cycle();
    end

    // Read miss at 0x1001C: four beats from the line base, five stalled cycles.
    sc = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0001_001C, 32'h0);
    @(negedge clk);
    sc += int'(stall);
    chk_outs("miss1c_req", o_idle(32'h0001_001C, 1'b1));
    for (int i = 0; i < LW; i++) begin
      next_cycle();
      @(negedge clk);
      sc += int'(stall);
      chk_outs($sformatf("miss1c_beat%0d", i), o_refill(32'h0001_0010, i));
    end
    line_valid[32'h0001_0010] = 1'b1;
    next_cycle();
    hit = 1'b1;
    @(negedge clk);
    sc += int'(stall);
    chk("miss1c_resolve_stall", 32'(stall), 32'd0);
    chk("miss1c_stall_cycles", 32'(sc), 32'd5);
    next_cycle();

    // Store hit then store miss at 0x10008.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, (k == 0), 32'h0001_0008, 32'hDEAD_BEEF);
      @(negedge clk);
      chk_outs($sformatf("store%0d_req", k), o_idle(32'h0001_0008, 1'b1));
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0);
      @(negedge clk);
      chk($sformatf("store%0d_mem_we", k), 32'(mem_we), 32'd1);
      chk($sformatf("store%0d_fill_en", k), 32'(fill_en), 32'(k == 0));
      chk_outs($sformatf("store%0d_write", k), o_write(32'h0001_0008, 32'hDEAD_BEEF, (k == 0)));
      next_cycle();
    end

    // Reset during the third refill beat aborts the line without tag_wr.
    drive(1'b1, 1'b0, 1'b0, 32'h0002_0000, 32'h0);
    @(negedge clk);
    chk_outs("abort_req", o_idle(32'h0002_0000, 1'b1));
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      chk_outs($sformatf("abort_beat%0d", i), o_refill(32'h0002_0000, i));
    end
    next_cycle();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs($sformatf("abort_rst%0d", i), o_idle(32'd0, 1'b0));
      next_cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk_outs("abort_after", o_idle(32'd0, 1'b0));
    next_cycle();
    // The aborted line is still invalid, so this must be a fresh full refill.
    t_read(32'h0002_0008, 1'b0);

    // Randomized traffic against the line-validity model.
    for (int n = 0; n < 150; n++) begin
      a = 32'h0004_0000 + 32'(($urandom % 32) * 4) + 32'($urandom % 4);
      case ($urandom % 4)
        0: begin
          drive(1'b0, 1'($urandom), 1'($urandom), a, $urandom);
          @(negedge clk);
          chk_outs("rnd_idle", o_idle(a, 1'b0));
          next_cycle();
        end
        1, 2: t_read(a, ($urandom % 3) == 0);
        default: t_write(a, $urandom);
      endcase
    end

    // Saturating counter: preload at the ceiling and just below it.
    sat_load = 1'b1; sat_val = 32'hFFFF_FFFF;
    next_cycle();
    sat_load = 1'b0; sat_inc = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("sat_hold_max", sat_cnt, 32'hFFFF_FFFF);
    next_cycle();
    sat_inc = 1'b0; sat_load = 1'b1; sat_val = 32'hFFFF_FFFD;
    next_cycle();
    sat_load = 1'b0; sat_inc = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("sat_step", sat_cnt, 32'hFFFF_FFFE);
    next_cycle();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("sat_reach_max", sat_cnt, 32'hFFFF_FFFF);
    next_cycle();
    sat_inc = 1'b0; sat_load = 1'b1; sat_val = 32'd5;
    next_cycle();
    sat_load = 1'b0; sat_inc = 1'b1;
    repeat (2) next_cycle();
    sat_inc = 1'b0;
    @(negedge clk);
    chk("sat_count", sat_cnt, 32'd7);
    next_cycle();

`ifdef CACHE_CTRL_PERF_EN
    do_reset();
    @(negedge clk);
    chk("perf_reset_hit", hit_cnt, 32'd0);
    chk("perf_reset_miss", miss_cnt, 32'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) t_read(32'h0001_0010 + 32'(4 * i), 1'b0);
    t_read(32'h9000_0000, 1'b1);
    t_read(32'h9000_0040, 1'b1);
    @(negedge clk);
    chk("perf_hit_cnt", hit_cnt, 32'd3);
    chk("perf_miss_cnt", miss_cnt, 32'd2);
    next_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
